// File: rtl/ingress_route_filter.sv
// Ingress route filter: one routing decision per packet from first-beat sideband,
// zero-latency pass-through or drop, with saturating pass/drop statistics.
module ingress_route_filter #(
   parameter  int unsigned AXIS_BUS_WIDTH   = 64,
   parameter  int unsigned AXIS_ID_WIDTH    = 4,
   parameter  int unsigned NUM_CONFIG_TYPES = 4,
   parameter  int unsigned ROUTE_MODE       = 0,
   parameter  int unsigned INCLUDE_UDP      = 1,
   parameter  int unsigned COUNT_WIDTH      = 32,
   localparam int unsigned NUM_BUS_BYTES    = AXIS_BUS_WIDTH / 8,
   localparam int unsigned NUM_AXIS_ID      = 2 ** AXIS_ID_WIDTH,
   localparam int unsigned CFG_IDX_WIDTH    = (NUM_CONFIG_TYPES > 1) ? $clog2(NUM_CONFIG_TYPES) : 1,
   localparam int unsigned DEST_WIDTH       = AXIS_ID_WIDTH + 1
) (
   input  logic                                   aclk,
   input  logic                                   aresetn,
   input  logic [AXIS_BUS_WIDTH-1:0]              axis_in_tdata,
   input  logic [NUM_BUS_BYTES-1:0]               axis_in_tkeep,
   input  logic                                   axis_in_tlast,
   input  logic                                   axis_in_tvalid,
   output logic                                   axis_in_tready,
   input  logic [NUM_AXIS_ID-1:0]                 route_mask,
   input  logic                                   poisoned,
   input  logic                                   is_config,
   input  logic [CFG_IDX_WIDTH-1:0]               config_idx,
   input  logic                                   has_udp_checksum_in,
   output logic [AXIS_BUS_WIDTH-1:0]              axis_out_tdata,
   output logic [NUM_BUS_BYTES-1:0]               axis_out_tkeep,
   output logic                                   axis_out_tlast,
   output logic                                   axis_out_tvalid,
   output logic [DEST_WIDTH-1:0]                  axis_out_tdest,
   input  logic                                   axis_out_tready,
   output logic                                   has_udp_checksum_out,
   input  logic [NUM_CONFIG_TYPES-1:0]            reroute_en,
   input  logic [NUM_CONFIG_TYPES*DEST_WIDTH-1:0] reroute_dest,
   input  logic                                   stat_clear,
   output logic [COUNT_WIDTH-1:0]                 pass_count,
   output logic [COUNT_WIDTH-1:0]                 drop_poison_count,
   output logic [COUNT_WIDTH-1:0]                 drop_noroute_count
);

   typedef enum logic [1:0] {ST_FIRST, ST_PASS, ST_DROP} state_t;

   state_t                   state, state_nxt;
   logic [DEST_WIDTH-1:0]    dest_reg;
   logic                     udp_reg;
   logic [AXIS_ID_WIDTH-1:0] rr_ptr;

   logic                     cfg_hit;
   logic [DEST_WIDTH-1:0]    cfg_dest;
   logic                     mask_found;
   logic [AXIS_ID_WIDTH-1:0] mask_sel;
   logic [AXIS_ID_WIDTH-1:0] scan_idx;
   logic [DEST_WIDTH-1:0]    dec_dest;
   logic                     drop_poison, drop_noroute;
   logic                     udp_first;
   logic                     first_hs, inc_pass, inc_poison, inc_noroute, rr_upd;

   assign axis_out_tdata = axis_in_tdata;
   assign axis_out_tkeep = axis_in_tkeep;
   assign axis_out_tlast = axis_in_tlast;

   // Per-packet decision from the current beat's sideband
   always_comb begin
      cfg_hit    = 1'b0;
      cfg_dest   = '0;
      mask_found = 1'b0;
      mask_sel   = '0;
      scan_idx   = '0;
      for (int k = 0; k < int'(NUM_CONFIG_TYPES); k++) begin
         if (is_config && config_idx == CFG_IDX_WIDTH'(k) && reroute_en[k]) begin
            cfg_hit  = 1'b1;
            cfg_dest = reroute_dest[k*DEST_WIDTH +: DEST_WIDTH];
         end
      end
      if (ROUTE_MODE == 0) begin
         for (int i = int'(NUM_AXIS_ID) - 1; i >= 0; i--) begin
            if (route_mask[i]) begin
               mask_found = 1'b1;
               mask_sel   = AXIS_ID_WIDTH'(i);
            end
         end
      end else begin
         for (int i = 0; i < int'(NUM_AXIS_ID); i++) begin
            scan_idx = rr_ptr + AXIS_ID_WIDTH'(i);
            if (!mask_found && route_mask[scan_idx]) begin
               mask_found = 1'b1;
               mask_sel   = scan_idx;
            end
         end
      end
      if (cfg_hit)         dec_dest = cfg_dest;
      else if (mask_found) dec_dest = {1'b0, mask_sel};
      else                 dec_dest = {1'b1, {AXIS_ID_WIDTH{1'b0}}};
      drop_poison  = poisoned;
      drop_noroute = !poisoned && dec_dest[DEST_WIDTH-1];
      udp_first    = has_udp_checksum_in && (INCLUDE_UDP != 0);
   end

   // Next state, handshake outputs and per-packet events
   always_comb begin
      state_nxt            = state;
      axis_out_tvalid      = 1'b0;
      axis_in_tready       = 1'b0;
      axis_out_tdest       = dest_reg;
      has_udp_checksum_out = udp_reg;
      first_hs             = 1'b0;
      inc_pass             = 1'b0;
      inc_poison           = 1'b0;
      inc_noroute          = 1'b0;
      rr_upd               = 1'b0;
      case (state)
         ST_FIRST: begin
            axis_out_tdest       = dec_dest;
            has_udp_checksum_out = udp_first;
            if (drop_poison || drop_noroute) begin
               axis_in_tready = 1'b1;
               if (axis_in_tvalid) begin
                  inc_poison  = drop_poison;
                  inc_noroute = drop_noroute;
                  state_nxt   = axis_in_tlast ? ST_FIRST : ST_DROP;
               end
            end else begin
               axis_out_tvalid = axis_in_tvalid;
               axis_in_tready  = axis_out_tready;
               if (axis_in_tvalid && axis_out_tready) begin
                  first_hs  = 1'b1;
                  inc_pass  = 1'b1;
                  rr_upd    = !cfg_hit;
                  state_nxt = axis_in_tlast ? ST_FIRST : ST_PASS;
               end
            end
         end
         ST_PASS: begin
            axis_out_tvalid = axis_in_tvalid;
            axis_in_tready  = axis_out_tready;
            if (axis_in_tvalid && axis_out_tready && axis_in_tlast) state_nxt = ST_FIRST;
         end
         ST_DROP: begin
            axis_in_tready = 1'b1;
            if (axis_in_tvalid && axis_in_tlast) state_nxt = ST_FIRST;
         end
         default: state_nxt = ST_FIRST;
      endcase
      if (!aresetn) begin
         axis_out_tvalid = 1'b0;
         axis_in_tready  = 1'b0;
      end
   end

   // Decision state
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state    <= ST_FIRST;
         dest_reg <= '0;
         udp_reg  <= 1'b0;
         rr_ptr   <= '0;
      end else begin
         state <= state_nxt;
         if (first_hs) begin
            dest_reg <= dec_dest;
            udp_reg  <= udp_first;
         end
         if (rr_upd) rr_ptr <= mask_sel + AXIS_ID_WIDTH'(1);
      end
   end

   // Saturating statistics; clear takes precedence over a same-cycle event
   always_ff @(posedge aclk) begin
      if (!aresetn || stat_clear) begin
         pass_count         <= '0;
         drop_poison_count  <= '0;
         drop_noroute_count <= '0;
      end else begin
         if (inc_pass && pass_count != '1)
            pass_count <= pass_count + COUNT_WIDTH'(1);
         if (inc_poison && drop_poison_count != '1)
            drop_poison_count <= drop_poison_count + COUNT_WIDTH'(1);
         if (inc_noroute && drop_noroute_count != '1)
            drop_noroute_count <= drop_noroute_count + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_ingress_route_filter.sv
// Directed bench: u0 is lowest-index routing with 2-bit counters, u1 is round-robin
// with 32-bit counters; both see the same input stream.
module tb_ingress_route_filter;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [63:0] in_tdata;
   logic [7:0]  in_tkeep;
   logic        in_tlast, in_tvalid;
   logic [15:0] route_mask;
   logic        poisoned, is_config, udp_in, out_tready, stat_clear;
   logic [1:0]  config_idx;
   logic [3:0]  reroute_en;
   logic [19:0] reroute_dest;

   logic [63:0] o0_tdata, o1_tdata;
   logic [7:0]  o0_tkeep, o1_tkeep;
   logic        o0_tlast, o1_tlast, o0_tvalid, o1_tvalid, o0_in_tready, o1_in_tready;
   logic [4:0]  o0_tdest, o1_tdest;
   logic        o0_udp, o1_udp;
   logic [1:0]  o0_pass, o0_poison, o0_noroute;
   logic [31:0] o1_pass, o1_poison, o1_noroute;

   int checks = 0;
   int errors = 0;
   int beats_out;

   always #5 aclk = ~aclk;

   ingress_route_filter #(.ROUTE_MODE(0), .COUNT_WIDTH(2)) u0 (
      .aclk(aclk), .aresetn(aresetn),
      .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_tlast(in_tlast),
      .axis_in_tvalid(in_tvalid), .axis_in_tready(o0_in_tready),
      .route_mask(route_mask), .poisoned(poisoned), .is_config(is_config),
      .config_idx(config_idx), .has_udp_checksum_in(udp_in),
      .axis_out_tdata(o0_tdata), .axis_out_tkeep(o0_tkeep), .axis_out_tlast(o0_tlast),
      .axis_out_tvalid(o0_tvalid), .axis_out_tdest(o0_tdest), .axis_out_tready(out_tready),
      .has_udp_checksum_out(o0_udp), .reroute_en(reroute_en), .reroute_dest(reroute_dest),
      .stat_clear(stat_clear), .pass_count(o0_pass), .drop_poison_count(o0_poison),
      .drop_noroute_count(o0_noroute));

   ingress_route_filter #(.ROUTE_MODE(1), .COUNT_WIDTH(32)) u1 (
      .aclk(aclk), .aresetn(aresetn),
      .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_tlast(in_tlast),
      .axis_in_tvalid(in_tvalid), .axis_in_tready(o1_in_tready),
      .route_mask(route_mask), .poisoned(poisoned), .is_config(is_config),
      .config_idx(config_idx), .has_udp_checksum_in(udp_in),
      .axis_out_tdata(o1_tdata), .axis_out_tkeep(o1_tkeep), .axis_out_tlast(o1_tlast),
      .axis_out_tvalid(o1_tvalid), .axis_out_tdest(o1_tdest), .axis_out_tready(out_tready),
      .has_udp_checksum_out(o1_udp), .reroute_en(reroute_en), .reroute_dest(reroute_dest),
      .stat_clear(stat_clear), .pass_count(o1_pass), .drop_poison_count(o1_poison),
      .drop_noroute_count(o1_noroute));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Single-beat packet; checks both destinations and output valid
   task automatic pkt1(input string tag, input logic [15:0] mask,
                       input logic [4:0] e0, input logic [4:0] e1, input logic ev);
      route_mask = mask;
      in_tvalid  = 1'b1;
      in_tlast   = 1'b1;
      @(negedge aclk);
      check({tag, ".u0_dest"}, 64'(o0_tdest), 64'(e0));
      check({tag, ".u1_dest"}, 64'(o1_tdest), 64'(e1));
      check({tag, ".valid"}, 64'({o0_tvalid, o1_tvalid}), 64'({ev, ev}));
      tick();
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
   endtask

   initial begin
      aresetn = 1'b0; in_tdata = '0; in_tkeep = 8'hFF; in_tlast = 1'b0; in_tvalid = 1'b1;
      route_mask = 16'h0001; poisoned = 1'b0; is_config = 1'b0; udp_in = 1'b0;
      out_tready = 1'b1; stat_clear = 1'b0; config_idx = '0; reroute_en = '0; reroute_dest = '0;
      tick();
      @(negedge aclk);
      check("rst.tvalid", 64'(o0_tvalid), 64'd0);
      check("rst.tready", 64'(o0_in_tready), 64'd0);
      check("rst.pass", 64'(o0_pass), 64'd0);
      tick();
      aresetn = 1'b1; in_tvalid = 1'b0;
      tick();

      // 3-beat pass, lowest bit of 0x0090 is 4; sideband ignored after beat 1
      beats_out = 0;
      route_mask = 16'h0090; udp_in = 1'b1; in_tvalid = 1'b1; in_tdata = 64'hDEAD_BEEF_0123_4567;
      for (int b = 0; b < 3; b++) begin
         in_tlast = (b == 2);
         @(negedge aclk);
         check("t1.dest", 64'(o0_tdest), 64'd4);
         check("t1.udp", 64'(o0_udp), 64'd1);
         if (o0_tvalid && out_tready) beats_out++;
         if (b == 0) check("t1.data", o0_tdata, 64'hDEAD_BEEF_0123_4567);
         tick();
         route_mask = 16'h0001; udp_in = 1'b0;
      end
      in_tvalid = 1'b0; in_tlast = 1'b0;
      @(negedge aclk);
      check("t1.beats", 64'(beats_out), 64'd3);
      check("t1.pass", 64'(o0_pass), 64'd1);
      tick();

      // Round-robin: u1 rr_ptr is 5 after test 1
      pkt1("rr1", 16'h0012, 5'd1, 5'd1, 1'b1);
      pkt1("rr2", 16'h0012, 5'd1, 5'd4, 1'b1);
      pkt1("rr3", 16'h0012, 5'd1, 5'd1, 1'b1);
      pkt1("rr4", 16'h0012, 5'd1, 5'd4, 1'b1);
      pkt1("rr5", 16'h0030, 5'd4, 5'd5, 1'b1);
      @(negedge aclk);
      check("sat.pass0", 64'(o0_pass), 64'd3);
      check("sat.pass1", 64'(o1_pass), 64'd6);
      tick();

      // Poisoned 4-beat packet with downstream stalled
      poisoned = 1'b1; route_mask = 16'h0001; out_tready = 1'b0; in_tvalid = 1'b1;
      for (int b = 0; b < 4; b++) begin
         in_tlast = (b == 3);
         @(negedge aclk);
         check("poi.tready", 64'(o0_in_tready), 64'd1);
         check("poi.tvalid", 64'(o0_tvalid), 64'd0);
         tick();
      end
      poisoned = 1'b0; out_tready = 1'b1; in_tvalid = 1'b0; in_tlast = 1'b0;
      @(negedge aclk);
      check("poi.count", 64'(o0_poison), 64'd1);
      tick();

      // Reroute of config type 2; rr_ptr (6) must not move
      is_config = 1'b1; config_idx = 2'd2; reroute_en = 4'b0100; reroute_dest = 20'h00C00;
      pkt1("rer.hit", 16'h8000, 5'd3, 5'd3, 1'b1);
      is_config = 1'b0;
      pkt1("rer.rrkeep", 16'h00B0, 5'd4, 5'd7, 1'b1);
      is_config = 1'b1; reroute_en = 4'b0000;
      pkt1("rer.off", 16'h8000, 5'd15, 5'd15, 1'b1);
      reroute_en = 4'b0100; reroute_dest = 20'h04000;
      pkt1("rer.msb", 16'h0001, 5'h10, 5'h10, 1'b0);
      is_config = 1'b0; reroute_en = 4'b0000;

      // No route: saturation then clear against a same-cycle drop
      for (int n = 0; n < 4; n++) pkt1("nor", 16'h0000, 5'h10, 5'h10, 1'b0);
      @(negedge aclk);
      check("nor.sat0", 64'(o0_noroute), 64'd3);
      check("nor.cnt1", 64'(o1_noroute), 64'd5);
      tick();
      stat_clear = 1'b1;
      pkt1("clr", 16'h0000, 5'h10, 5'h10, 1'b0);
      stat_clear = 1'b0;
      @(negedge aclk);
      check("clr.noroute0", 64'(o0_noroute), 64'd0);
      check("clr.noroute1", 64'(o1_noroute), 64'd0);
      check("clr.pass0", 64'(o0_pass), 64'd0);
      check("clr.poison0", 64'(o0_poison), 64'd0);
      tick();

      // Stalls, then reset mid-packet
      route_mask = 16'h0004; in_tvalid = 1'b1; in_tlast = 1'b0; out_tready = 1'b0;
      @(negedge aclk);
      check("stl.dest_a", 64'(o0_tdest), 64'd2);
      check("stl.tready", 64'(o0_in_tready), 64'd0);
      tick();
      @(negedge aclk);
      check("stl.dest_b", 64'(o0_tdest), 64'd2);
      tick();
      out_tready = 1'b1;
      @(negedge aclk);
      check("stl.dest_c", 64'(o1_tdest), 64'd2);
      tick();
      out_tready = 1'b0; route_mask = 16'h0001;
      @(negedge aclk);
      check("stl.held", 64'(o0_tdest), 64'd2);
      check("stl.pass", 64'(o0_pass), 64'd1);
      tick();
      aresetn = 1'b0;
      @(negedge aclk);
      check("mrst.tvalid", 64'(o0_tvalid), 64'd0);
      check("mrst.tready", 64'(o0_in_tready), 64'd0);
      tick();
      aresetn = 1'b1; out_tready = 1'b1; route_mask = 16'h0009;
      @(negedge aclk);
      check("mrst.pass", 64'(o0_pass), 64'd0);
      check("mrst.dest0", 64'(o0_tdest), 64'd0);
      check("mrst.dest1", 64'(o1_tdest), 64'd0);
      check("mrst.valid", 64'(o0_tvalid), 64'd1);
      tick();
      in_tlast = 1'b1;
      tick();
      in_tvalid = 1'b0; in_tlast = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ingress_route_filter.md
Name: ingress_route_filter

Overview:
- Second-generation ingress filter. Sits after the parse-wait buffer and before de-encap.
- Takes a packet stream whose first beat carries per-packet sideband (route mask, poison, config-etype index, UDP checksum flag) and makes one routing decision per packet.
- Adds multiple reroutable config etypes, selectable lowest-index or round-robin destination choice, per-packet decision hold, and saturating pass/drop statistics counters.

Parameters:
- AXIS_BUS_WIDTH, 64, data width in bits; NUM_BUS_BYTES = AXIS_BUS_WIDTH/8.
- AXIS_ID_WIDTH, 4, destination ID width; NUM_AXIS_ID = 2**AXIS_ID_WIDTH.
- NUM_CONFIG_TYPES, 4, number of config etypes that can be rerouted; CFG_IDX_WIDTH = max(1,clog2(NUM_CONFIG_TYPES)).
- ROUTE_MODE, 0, 0 = lowest set mask bit wins; 1 = round-robin among set mask bits.
- INCLUDE_UDP, 1, 0 ties has_udp_checksum_out to 0.
- COUNT_WIDTH, 32, statistics counter width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- axis_in_tdata/tkeep/tlast/tvalid  in  AXIS_BUS_WIDTH/NUM_BUS_BYTES/1/1  input stream.
- axis_in_tready  out  1  input ready.
- route_mask  in  NUM_AXIS_ID  candidate destinations; valid on the first beat only.
- poisoned  in  1  packet error flag; valid on the first beat.
- is_config  in  1  packet is a config etype; valid on the first beat.
- config_idx  in  CFG_IDX_WIDTH  which config etype; valid on the first beat.
- has_udp_checksum_in  in  1  valid on the first beat.
- axis_out_tdata/tkeep/tlast/tvalid  out  as input  output stream.
- axis_out_tdest  out  AXIS_ID_WIDTH+1  destination; MSB=1 means unroutable.
- axis_out_tready  in  1  downstream ready.
- has_udp_checksum_out  out  1  held for the whole packet.
- reroute_en  in  NUM_CONFIG_TYPES  per-type reroute enable.
- reroute_dest  in  NUM_CONFIG_TYPES*(AXIS_ID_WIDTH+1)  flat per-type reroute destination; type k at bits [k*(W)+:W].
- stat_clear  in  1  synchronous clear of all counters.
- pass_count, drop_poison_count, drop_noroute_count  out  COUNT_WIDTH each  statistics.

Behaviour:
- Zero-latency datapath: tdata/tkeep/tlast pass straight through. No internal storage other than decision state.
- FSM states:
  - FIRST: next accepted beat is a first beat.
  - PASS: mid-packet, forwarding.
  - DROP: mid-packet, discarding.
  - Reset state is FIRST.
- Decision in FIRST, evaluated combinationally from the current beat's sideband, in priority order:
  1. poisoned=1 → drop, reason POISON.
  2. is_config=1, config_idx<NUM_CONFIG_TYPES and reroute_en[config_idx]=1 → dest=reroute_dest[config_idx].
  3. Otherwise, mask selection:
     - ROUTE_MODE 0: lowest set bit.
     - ROUTE_MODE 1: first set bit at index ≥ rr_ptr, scanning upward with wrap.
     - mask=0 → dest={1'b1,0}.
  4. dest MSB=1 (including a reroute_dest with MSB set) → drop, reason NOROUTE.
- Pass handling:
  - axis_out_tvalid=axis_in_tvalid; axis_in_tready=axis_out_tready; tdest=decision.
  - On the first-beat handshake: latch dest_reg and udp_reg; go to PASS unless tlast, which returns to FIRST.
- Drop handling:
  - axis_out_tvalid=0; axis_in_tready=1.
  - On the first beat: go to DROP unless tlast, which stays in FIRST.
- In PASS:
  - tdest=dest_reg; has_udp_checksum_out=udp_reg.
  - Sideband inputs are ignored.
  - Exit to FIRST on the tlast handshake.
- In DROP:
  - tready=1, tvalid=0.
  - Exit to FIRST on the tlast beat.
- has_udp_checksum_out in FIRST follows has_udp_checksum_in & INCLUDE_UDP.
- tdest and decision must not change while tvalid=1 and tready=0 in FIRST. Upstream holds sideband stable per AXIS rules.
- rr_ptr (AXIS_ID_WIDTH bits):
  - Reset 0.
  - Updates only on the first-beat handshake of a mask-routed passed packet: rr_ptr = chosen+1, wrapping naturally modulo NUM_AXIS_ID.
  - Rerouted or dropped packets do not move it.
- Counters:
  - Each increments by 1 once per packet, at the first-beat acceptance.
  - Saturate at all-ones.
  - stat_clear wins over a same-cycle increment (that event is not counted).
  - Reset value 0.
- Reset values: state FIRST; dest_reg 0; udp_reg 0; rr_ptr 0; counters 0.
- Combinational outputs follow the FIRST-state rules. axis_out_tvalid is 0 while aresetn=0, and axis_in_tready is 0 during reset.
- Reset mid-packet: the FSM returns to FIRST, and the next beat is treated as a first beat. Upstream is reset by the same aresetn.
- Single-beat packets (tlast on the first beat) never leave FIRST.

Test Plan:
- Mode 0, mask=16'h0090, 3-beat packet, tready=1 → tdest=4 on all beats; pass_count=1; 3 beats out.
- Mode 1, mask=16'h0012, four 1-beat packets → tdest sequence 1,4,1,4; rr_ptr ends at 5.
- poisoned=1 with mask=1, 4-beat packet while tready=0 → in_tready=1 for all 4 beats; out_tvalid never 1; drop_poison_count=1.
- is_config=1, config_idx=2, reroute_en=4'b0100, reroute_dest[2]=5'h03, mask=16'h8000 → tdest=3; rr_ptr unchanged. The same packet with reroute_en=0 → tdest=15.
- mask=0 → packet dropped, drop_noroute_count=1. With COUNT_WIDTH=2, 5 drops → count stays 3; stat_clear together with a drop → count 0.
- Pass packet with tready toggling every cycle, then aresetn low on beat 2 → tdest stable while stalled; after reset, state is FIRST, counters 0, and the next beat is decided fresh.
